uart_pkt_tx: RTL and testbench

Parametrised UART packet framer/transmitter, the synthesizable successor of the host-side packet generator used in bench stimulus. Frames each transfer as PREFIX, addr, len, len payload bytes, check byte, and serialises it 8N1 on tx with a configurable inter-byte gap. Sits between an internal payload source (register readback, ADC results) and the host UART. Baud rate, maximum length, gap and check-byte mode are set by parameters.

---
 rtl/uart_pkt_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_pkt_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_tx.sv
// UART packet framer: sends PREFIX, addr, len, payload bytes and a check byte,
// each serialised 8N1 on tx and followed by GAP_BITS idle bit-times.
module uart_pkt_tx #(
    parameter int unsigned SYS_CLK_HZ = 100_000_000,
    parameter int unsigned BAUDRATE   = 115_200,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned GAP_BITS   = 3,
    parameter logic [7:0]  PREFIX     = 8'hDD,
    parameter bit          CRC_MODE   = 1'b1,
    parameter logic [7:0]  CRC_CONST  = 8'hCC
) (
    input  logic       clk_100,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       tx
);
    localparam int unsigned   DIV       = SYS_CLK_HZ / BAUDRATE;
    localparam int unsigned   TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(DIV - 1);
    localparam logic [3:0]    GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    logic [7:0]    addr_q;
    logic [7:0]    len_q;
    logic [7:0]    acc;
    logic [7:0]    shreg;
    logic [8:0]    idx;
    logic [2:0]    bit_cnt;
    logic [3:0]    gap_cnt;
    logic [TW-1:0] timer;

    logic [8:0] last_idx;
    logic [8:0] next_idx;
    logic       timer_done;
    logic       last_byte;
    logic       payload_next;
    logic       len_ok;
    logic       byte_end;
    logic [7:0] hdr_byte;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        last_idx     = {1'b0, len_q} + 9'd3;
        next_idx     = idx + 9'd1;
        timer_done   = (timer == T_LAST);
        last_byte    = (idx == last_idx);
        payload_next = (next_idx >= 9'd3) && (next_idx < last_idx);
        len_ok       = (len != 8'd0) && (len <= MAX_LEN_B);
        byte_end     = 1'b0;
        if (timer_done) begin
            if (state == S_STOP && GAP_BITS == 0) begin
                byte_end = 1'b1;
            end else if (state == S_GAP && gap_cnt == GAP_LAST) begin
                byte_end = 1'b1;
            end
        end
        case (idx)
            9'd0:    hdr_byte = PREFIX;
            9'd1:    hdr_byte = addr_q;
            9'd2:    hdr_byte = len_q;
            default: hdr_byte = CRC_MODE ? acc : CRC_CONST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk_100) begin
        if (rst) begin
            // NOTE: every register, datapath included, is cleared so an aborted packet leaves no residue.
            state   <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            acc     <= '0;
            shreg   <= '0;
            idx     <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            timer   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            timer <= timer_done ? '0 : timer + TW'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            addr_q <= addr;
                            len_q  <= len;
                            acc    <= addr ^ len;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= S_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                // s_ready is set on entry only for payload indices, so it doubles as the byte-type flag
                S_LOAD: begin
                    timer <= '0;
                    if (s_ready) begin
                        if (s_valid) begin
                            shreg   <= s_data;
                            acc     <= acc ^ s_data;
                            s_ready <= 1'b0;
                            tx      <= 1'b0;
                            state   <= S_START;
                        end
                    end else begin
                        shreg <= hdr_byte;
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end

                S_START: begin
                    if (timer_done) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (timer_done) begin
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                S_STOP: begin
                    if (timer_done && GAP_BITS != 0) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (timer_done && gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase

            // End of a byte's idle tail: fetch the next byte or finish the packet
            if (byte_end) begin
                if (last_byte) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end else begin
                    idx     <= next_idx;
                    s_ready <= payload_next;
                    state   <= S_LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_pkt_tx.sv
// Self-checking bench for uart_pkt_tx: a table of packets plus hand-written stall,
// mid-packet start and reset-abort sequences; a line decoder pops an expected-byte queue.
module tb_uart_pkt_tx;
    localparam int DIV   = 10;
    localparam int GAP_A = 3;
    localparam int GAP_B = 0;

    typedef struct {
        bit         sel;
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] base;
        logic [7:0] step;
        bit         exp_err;
    } vec_t;

    logic       clk_100 = 1'b0;
    logic       rst     = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] addr    = '0;
    logic [7:0] len     = '0;
    logic [7:0] s_data  = '0;
    logic       s_valid = 1'b0;
    logic       s_ready_a, busy_a, done_a, err_a, tx_a;
    logic       s_ready_b, busy_b, done_b, err_b, tx_b;
    bit         sel = 1'b0;
    logic       s_ready_m, busy_m, done_m, err_m, tx_m;

    assign s_ready_m = sel ? s_ready_b : s_ready_a;
    assign busy_m    = sel ? busy_b    : busy_a;
    assign done_m    = sel ? done_b    : done_a;
    assign err_m     = sel ? err_b     : err_a;
    assign tx_m      = sel ? tx_b      : tx_a;

    uart_pkt_tx #(.SYS_CLK_HZ(100_000_000), .BAUDRATE(10_000_000), .MAX_LEN(64),
                  .GAP_BITS(GAP_A), .PREFIX(8'hDD), .CRC_MODE(1'b1), .CRC_CONST(8'hCC)) dut_a (
        .clk_100(clk_100), .rst(rst), .start(start_a), .addr(addr), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a), .busy(busy_a),
        .done(done_a), .err(err_a), .tx(tx_a));

    uart_pkt_tx #(.SYS_CLK_HZ(100_000_000), .BAUDRATE(10_000_000), .MAX_LEN(64),
                  .GAP_BITS(GAP_B), .PREFIX(8'hDD), .CRC_MODE(1'b0), .CRC_CONST(8'hCC)) dut_b (
        .clk_100(clk_100), .rst(rst), .start(start_b), .addr(addr), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b), .busy(busy_b),
        .done(done_b), .err(err_b), .tx(tx_b));

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Line decoder and scoreboard
    logic [7:0] exp_q[$];
    int         falls[$];
    int         rx_cnt = 0, glitch = 0, hs_cnt = 0, done_cnt = 0, viol = 0;
    bit         mon_en = 1'b1, mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = '0;
    logic       mon_ref = 1'b0;

    always @(negedge clk_100) begin
        int k;
        logic [7:0] e;
        if (rst || !mon_en) begin
            mon_act = 1'b0;
            mon_cnt = 0;
        end else if (!mon_act) begin
            if (tx_m === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                mon_ref = 1'b0;
                falls.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % DIV == 0) mon_ref = tx_m;
            else if (tx_m !== mon_ref) glitch++;
            if (mon_cnt % DIV == DIV / 2) begin
                k = mon_cnt / DIV;
                if (k == 0) begin
                    check("start_bit", {31'd0, tx_m}, 32'd0);
                end else if (k <= 8) begin
                    mon_sh[k-1] = tx_m;
                end else begin
                    check("stop_bit", {31'd0, tx_m}, 32'd1);
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL rx_unexpected: got %02h expected no byte", mon_sh);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, mon_sh}, {24'd0, e});
                    end
                end
            end
            if (mon_cnt == 10 * DIV - 1) mon_act = 1'b0;
        end
    end

    always @(negedge clk_100) begin
        if (s_valid && s_ready_m) hs_cnt++;
        if (done_m) done_cnt++;
        if ((s_ready_a && !busy_a) || (s_ready_b && !busy_b)) viol++;
    end

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk_100);
            t++;
        end while (s_ready_m !== 1'b1 && t < 3000);
        if (s_ready_m !== 1'b1) fail_now("s_ready_wait");
    endtask

    task automatic pulse_start(input bit which);
        @(posedge clk_100); #1;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk_100); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_packet(input vec_t v, input int stall_at, input bit mid_start);
        logic [7:0] pl[$];
        logic [7:0] chk;
        int gap, start_cyc, done_cyc, bad, t, first_fall, last_fall;
        sel = v.sel;
        gap = v.sel ? GAP_B : GAP_A;
        chk = v.addr ^ v.len;
        pl.delete();
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.len); i++) begin
                pl.push_back(v.base + 8'(i) * v.step);
                chk ^= pl[i];
            end
            if (v.sel) chk = 8'hCC;
        end
        hs_cnt = 0; done_cnt = 0; rx_cnt = 0; glitch = 0;
        falls.delete();
        if (!v.exp_err) begin
            exp_q.push_back(8'hDD);
            exp_q.push_back(v.addr);
            exp_q.push_back(v.len);
            foreach (pl[i]) exp_q.push_back(pl[i]);
            exp_q.push_back(chk);
        end
        addr = v.addr;
        len  = v.len;
        @(posedge clk_100); #1;
        start_cyc = cyc;
        if (v.sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk_100); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk_100);
        check("err_after_start", {31'd0, err_m}, {31'd0, v.exp_err});
        check("busy_after_start", {31'd0, busy_m}, {31'd0, !v.exp_err});
        check("tx_in_load", {31'd0, tx_m}, 32'd1);

        if (v.exp_err) begin
            @(negedge clk_100);
            check("err_one_cycle", {31'd0, err_m}, 32'd0);
            bad = 0;
            repeat (20) begin
                @(negedge clk_100);
                if (tx_m !== 1'b1 || s_ready_m !== 1'b0 || busy_m !== 1'b0) bad++;
            end
            check("rejected_line_quiet", bad, 0);
            check("rejected_no_bytes", rx_cnt, 0);
            return;
        end

        @(negedge clk_100);
        check("tx_falls_n_plus_2", {31'd0, tx_m}, 32'd0);

        if (mid_start) begin
            repeat (150) @(negedge clk_100);
            @(posedge clk_100); #1;
            start_a = 1'b1; start_b = 1'b1; addr = 8'h77; len = 8'd5;
            @(posedge clk_100); #1;
            start_a = 1'b0; start_b = 1'b0; addr = v.addr; len = v.len;
        end

        s_valid = 1'b1;
        for (int i = 0; i < int'(v.len); i++) begin
            s_data = pl[i];
            if (i == stall_at) begin
                s_valid = 1'b0;
                wait_ready();
                bad = 0;
                repeat (50) begin
                    @(negedge clk_100);
                    if (tx_m !== 1'b1 || s_ready_m !== 1'b1) bad++;
                end
                check("stall_line_idle_ready_high", bad, 0);
                @(posedge clk_100); #1;
                s_valid = 1'b1;
            end
            wait_ready();
            @(posedge clk_100); #1;
        end
        s_valid = 1'b0;

        t = 0;
        do begin
            @(negedge clk_100);
            t++;
        end while (done_m !== 1'b1 && t < 20000);
        if (done_m !== 1'b1) begin
            fail_now("done_wait");
            return;
        end
        done_cyc = cyc;
        check("busy_during_done", {31'd0, busy_m}, 32'd1);
        @(negedge clk_100);
        check("done_one_cycle", {31'd0, done_m}, 32'd0);
        check("busy_after_done", {31'd0, busy_m}, 32'd0);
        repeat (20) @(negedge clk_100);
        #1;
        first_fall = (falls.size() > 0) ? falls[0] : -1;
        last_fall  = (falls.size() > 0) ? falls[falls.size()-1] : -1;
        check("start_to_fall", first_fall - start_cyc, 2);
        check("fall_to_done", done_cyc - last_fall, (10 + gap) * DIV);
        check("byte_count", rx_cnt, int'(v.len) + 4);
        check("queue_drained", exp_q.size(), 0);
        check("handshakes", hs_cnt, int'(v.len));
        check("done_pulses", done_cnt, 1);
        check("bit_width_glitches", glitch, 0);
        if (stall_at < 0) begin
            bad = 0;
            for (int i = 1; i < falls.size(); i++)
                if (falls[i] - falls[i-1] != (10 + gap) * DIV + 1) bad++;
            check("byte_spacing", bad, 0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int bad, t;
        vecs[0] = '{1'b0, 8'h08, 8'd2,   8'h16, 8'h07, 1'b0};
        vecs[1] = '{1'b1, 8'h13, 8'd1,   8'h09, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h55, 8'd0,   8'h00, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h55, 8'd65,  8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 8'h40, 8'd200, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 8'h3C, 8'd64,  8'h01, 8'h01, 1'b0};
        vecs[6] = '{1'b1, 8'hA5, 8'd3,   8'hF0, 8'h11, 1'b0};
        vecs[7] = '{1'b0, 8'h7E, 8'd1,   8'h80, 8'h00, 1'b0};

        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        check("rst_tx_a", {31'd0, tx_a}, 32'd1);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_flags_a", {29'd0, done_a, err_a, s_ready_a}, 32'd0);
        check("rst_tx_b", {31'd0, tx_b}, 32'd1);
        check("rst_flags_b", {28'd0, busy_b, done_b, err_b, s_ready_b}, 32'd0);
        @(posedge clk_100); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_packet(vecs[i], -1, 1'b0);

        // Payload source stalls before the second payload byte
        run_packet(vecs[0], 1, 1'b0);
        // start pulse while a packet is in flight must be ignored
        run_packet(vecs[0], -1, 1'b1);

        // Reset during data bit 3 of the addr byte (addr 00, so the line is low there)
        sel = 1'b0;
        mon_en = 1'b0;
        addr = 8'h00;
        len  = 8'd1;
        pulse_start(1'b0);
        t = 0;
        do begin
            @(negedge clk_100);
            t++;
        end while (tx_m !== 1'b0 && t < 100);
        if (tx_m !== 1'b0) fail_now("abort_fall_wait");
        repeat (130 + 44) @(negedge clk_100);
        check("abort_tx_low_before_rst", {31'd0, tx_m}, 32'd0);
        @(posedge clk_100); #1;
        rst = 1'b1;
        @(posedge clk_100); #1;
        rst = 1'b0;
        @(negedge clk_100);
        check("abort_tx_high", {31'd0, tx_m}, 32'd1);
        check("abort_busy_low", {31'd0, busy_m}, 32'd0);
        check("abort_flags_low", {30'd0, s_ready_m, done_m}, 32'd0);
        bad = 0;
        repeat (300) begin
            @(negedge clk_100);
            if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
        end
        check("abort_line_stays_idle", bad, 0);
        mon_en = 1'b1;
        run_packet(vecs[0], -1, 1'b0);

        check("s_ready_only_while_busy", viol, 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
